// File: rtl/clock_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | clock_pkg: state encodings and counter width shared by the      |
// | clock_divider / period_meter family.                            |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package clock_pkg;

   localparam int DEFAULT_COUNTER_SIZE = 24;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } meter_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sync_edge_detect: 2-flop synchronizer plus history flop,        |
// | giving a clean level and a one-cycle rising-edge pulse.         |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module sync_edge_detect (
   input  logic clock_in,
   input  logic reset_n,
   input  logic signal_in,
   output logic level,
   output logic rise
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= signal_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign level = r_s2;
   assign rise  = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | period_meter: measures period and high time of a slow async     |
// | square wave in clock_in cycles, with lock and timeout flags.    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module period_meter
   import clock_pkg::*;
#(
   parameter int COUNTER_SIZE  = DEFAULT_COUNTER_SIZE,
   parameter int TIMEOUT_COUNT = 16777215
) (
   input  logic                    clock_in,
   input  logic                    reset_n,
   input  logic                    signal_in,
   output logic [COUNTER_SIZE-1:0] period_out,
   output logic [COUNTER_SIZE-1:0] high_out,
   output logic                    period_valid,
   output logic                    locked,
   output logic                    timeout_out
);

   localparam logic [COUNTER_SIZE-1:0] c_TIMEOUT = COUNTER_SIZE'(TIMEOUT_COUNT);
   localparam logic [COUNTER_SIZE-1:0] c_ONE     = COUNTER_SIZE'(1);

   logic                    w_level;
   logic                    w_rise;
   meter_state_t            r_state;
   logic [COUNTER_SIZE-1:0] r_cnt;
   logic [COUNTER_SIZE-1:0] r_hcnt;

   sync_edge_detect u_sync (
      .clock_in  (clock_in),
      .reset_n   (reset_n),
      .signal_in (signal_in),
      .level     (w_level),
      .rise      (w_rise)
   );

   // Both counters restart at 1 because the rise cycle itself belongs to the new interval.
   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_hcnt       <= '0;
         period_out   <= '0;
         high_out     <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout_out  <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  r_cnt   <= c_ONE;
                  r_hcnt  <= c_ONE;
                  r_state <= ST_MEASURE;
               end
            end
            ST_MEASURE: begin
               if (w_rise) begin
                  period_out   <= r_cnt;
                  high_out     <= r_hcnt;
                  period_valid <= 1'b1;
                  locked       <= 1'b1;
                  timeout_out  <= 1'b0;
                  r_cnt        <= c_ONE;
                  r_hcnt       <= c_ONE;
               end else begin
                  r_cnt  <= r_cnt + c_ONE;
                  r_hcnt <= r_hcnt + COUNTER_SIZE'(w_level);
                  // Timeout is below 2^COUNTER_SIZE, so it fires before any wrap.
                  if (r_cnt == c_TIMEOUT) begin
                     r_state     <= ST_IDLE;
                     timeout_out <= 1'b1;
                     locked      <= 1'b0;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
